// File: rtl/router_vc_input.sv
// Ring router input port: two virtual-channel FIFOs (even/odd) whose write/drain roles
// swap with the link polarity, plus hop-based routing of each head flit.
module router_vc_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 8,
  parameter int PTR_W      = 3,
  parameter int HOP_MSB    = 55,
  parameter int HOP_LSB    = 48
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  gnt_fwd,
  input  logic                  gnt_pe,
  output logic                  req_fwd,
  output logic                  req_pe,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] data_fwd,
  output logic [DATA_WIDTH-1:0] data_pe,
  output logic [PTR_W:0]        count
);
  localparam int HOP_W = HOP_MSB - HOP_LSB + 1;
  localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ZERO  = {(PTR_W+1){1'b0}};
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1'b1);
  localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1'b1);
  localparam logic [HOP_W-1:0] HOP_ZERO  = {HOP_W{1'b0}};
  localparam logic [HOP_W-1:0] HOP_ONE   = HOP_W'(1'b1);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [PTR_W:0]        count_r;
  logic [DATA_WIDTH-1:0] head_s;
  logic                  pop_s;

  function automatic logic [DATA_WIDTH-1:0] dec_hop(input logic [DATA_WIDTH-1:0] flit);
    logic [DATA_WIDTH-1:0] res;
    res = flit;
    res[HOP_MSB:HOP_LSB] = flit[HOP_MSB:HOP_LSB] - HOP_ONE;
    return res;
  endfunction

  // Head decode: route by hop field, requests gated by read phase and occupancy
  always_comb begin
    head_s   = mem_r[rd_ptr_r];
    req_fwd  = 1'b0;
    req_pe   = 1'b0;
    if (rd_en && (count_r != CNT_ZERO)) begin
      if (head_s[HOP_MSB:HOP_LSB] == HOP_ZERO) begin
        req_pe = 1'b1;
      end else begin
        req_fwd = 1'b1;
      end
    end else begin
      req_fwd = 1'b0;
      req_pe  = 1'b0;
    end
    pop_s    = (gnt_fwd & req_fwd) | (gnt_pe & req_pe);
    full     = (count_r == FULL_CNT);
    data_fwd = dec_hop(head_s);
    data_pe  = head_s;
    count    = count_r;
  end

  // Pointer and occupancy state; push and pop never coincide on one VC
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Flit storage, deliberately left unreset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= data_in;
    end
  end
endmodule

module router_vc_input #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 8,
  parameter int PTR_W      = 3,
  parameter int HOP_MSB    = 55,
  parameter int HOP_LSB    = 48
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  polarity,
  input  logic                  si,
  output logic                  ri,
  input  logic [DATA_WIDTH-1:0] di,
  output logic                  req_fwd_even,
  output logic                  req_fwd_odd,
  output logic                  req_pe_even,
  output logic                  req_pe_odd,
  input  logic                  gnt_fwd_even,
  input  logic                  gnt_fwd_odd,
  input  logic                  gnt_pe_even,
  input  logic                  gnt_pe_odd,
  output logic [DATA_WIDTH-1:0] data_out_fwd_even,
  output logic [DATA_WIDTH-1:0] data_out_fwd_odd,
  output logic [DATA_WIDTH-1:0] data_out_pe_even,
  output logic [DATA_WIDTH-1:0] data_out_pe_odd,
  output logic [PTR_W:0]        count_even,
  output logic [PTR_W:0]        count_odd,
  output logic                  drop_err
);
  logic full_even_s;
  logic full_odd_s;
  logic push_even_s;
  logic push_odd_s;
  logic drop_err_r;

  // polarity=1 writes odd and drains even; polarity=0 the reverse
  always_comb begin
    if (polarity) begin
      ri = !full_odd_s;
    end else begin
      ri = !full_even_s;
    end
    push_even_s = si & ri & !polarity;
    push_odd_s  = si & ri & polarity;
    drop_err    = drop_err_r;
  end

  // Sticky flag for any strobe that arrived while not ready
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_err_r <= 1'b0;
    end else if (si && !ri) begin
      drop_err_r <= 1'b1;
    end
  end

  router_vc_fifo #(
    .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W),
    .HOP_MSB(HOP_MSB), .HOP_LSB(HOP_LSB)
  ) u_even (
    .clk(clk), .rst(rst), .push(push_even_s), .rd_en(polarity), .data_in(di),
    .gnt_fwd(gnt_fwd_even), .gnt_pe(gnt_pe_even),
    .req_fwd(req_fwd_even), .req_pe(req_pe_even), .full(full_even_s),
    .data_fwd(data_out_fwd_even), .data_pe(data_out_pe_even), .count(count_even)
  );

  router_vc_fifo #(
    .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W),
    .HOP_MSB(HOP_MSB), .HOP_LSB(HOP_LSB)
  ) u_odd (
    .clk(clk), .rst(rst), .push(push_odd_s), .rd_en(!polarity), .data_in(di),
    .gnt_fwd(gnt_fwd_odd), .gnt_pe(gnt_pe_odd),
    .req_fwd(req_fwd_odd), .req_pe(req_pe_odd), .full(full_odd_s),
    .data_fwd(data_out_fwd_odd), .data_pe(data_out_pe_odd), .count(count_odd)
  );
endmodule

// File: tb/tb_router_vc_input.sv
// Bench for router_vc_input: directed vector table, hand-written corner sequences and
// randomized traffic, all checked against a queue-based reference model.
module tb_router_vc_input;
  logic        clk;
  logic        rst;
  logic        polarity;
  logic        si;
  logic        ri;
  logic [63:0] di;
  logic        req_fwd_even, req_fwd_odd, req_pe_even, req_pe_odd;
  logic        gnt_fwd_even, gnt_fwd_odd, gnt_pe_even, gnt_pe_odd;
  logic [63:0] data_out_fwd_even, data_out_fwd_odd, data_out_pe_even, data_out_pe_odd;
  logic [3:0]  count_even, count_odd;
  logic        drop_err;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: one queue per VC plus the sticky drop flag
  logic [63:0] q_e[$];
  logic [63:0] q_o[$];
  bit          m_drop;
  bit          m_ri, m_rfe, m_rpe, m_rfo, m_rpo;

  router_vc_input dut (
    .clk(clk), .rst(rst), .polarity(polarity), .si(si), .ri(ri), .di(di),
    .req_fwd_even(req_fwd_even), .req_fwd_odd(req_fwd_odd),
    .req_pe_even(req_pe_even), .req_pe_odd(req_pe_odd),
    .gnt_fwd_even(gnt_fwd_even), .gnt_fwd_odd(gnt_fwd_odd),
    .gnt_pe_even(gnt_pe_even), .gnt_pe_odd(gnt_pe_odd),
    .data_out_fwd_even(data_out_fwd_even), .data_out_fwd_odd(data_out_fwd_odd),
    .data_out_pe_even(data_out_pe_even), .data_out_pe_odd(data_out_pe_odd),
    .count_even(count_even), .count_odd(count_odd), .drop_err(drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [63:0] hop_dec(input logic [63:0] f);
    logic [63:0] r;
    r = f;
    r[55:48] = f[55:48] - 8'd1;
    return r;
  endfunction

  task automatic set_in(input bit pol, input bit s, input logic [63:0] d, input logic [3:0] g);
    polarity = pol;
    si = s;
    di = d;
    {gnt_fwd_even, gnt_fwd_odd, gnt_pe_even, gnt_pe_odd} = g;
    #1;
  endtask

  task automatic model_check();
    m_ri  = polarity ? (q_o.size() < 8) : (q_e.size() < 8);
    m_rfe = 1'b0; m_rpe = 1'b0; m_rfo = 1'b0; m_rpo = 1'b0;
    if (polarity && q_e.size() > 0) begin
      if (q_e[0][55:48] == 8'd0) m_rpe = 1'b1;
      else m_rfe = 1'b1;
    end
    if (!polarity && q_o.size() > 0) begin
      if (q_o[0][55:48] == 8'd0) m_rpo = 1'b1;
      else m_rfo = 1'b1;
    end
    chk("ri", ri, m_ri);
    chk("req_fwd_even", req_fwd_even, m_rfe);
    chk("req_pe_even", req_pe_even, m_rpe);
    chk("req_fwd_odd", req_fwd_odd, m_rfo);
    chk("req_pe_odd", req_pe_odd, m_rpo);
    chk("count_even", count_even, q_e.size());
    chk("count_odd", count_odd, q_o.size());
    chk("drop_err", drop_err, m_drop);
    if (m_rfe) chk("data_out_fwd_even", data_out_fwd_even, hop_dec(q_e[0]));
    if (m_rpe) chk("data_out_pe_even", data_out_pe_even, q_e[0]);
    if (m_rfo) chk("data_out_fwd_odd", data_out_fwd_odd, hop_dec(q_o[0]));
    if (m_rpo) chk("data_out_pe_odd", data_out_pe_odd, q_o[0]);
  endtask

  // Check, clock, then advance the model with the values seen before the edge
  task automatic tick();
    bit pop_e, pop_o, push;
    logic [63:0] d;
    model_check();
    pop_e = (gnt_fwd_even && m_rfe) || (gnt_pe_even && m_rpe);
    pop_o = (gnt_fwd_odd && m_rfo) || (gnt_pe_odd && m_rpo);
    push  = si && m_ri;
    d     = di;
    if (si && !m_ri) m_drop = 1'b1;
    @(posedge clk);
    if (pop_e) void'(q_e.pop_front());
    if (pop_o) void'(q_o.pop_front());
    if (push) begin
      if (polarity) q_o.push_back(d);
      else q_e.push_back(d);
    end
    #1;
  endtask

  task automatic cyc(input bit pol, input bit s, input logic [63:0] d, input logic [3:0] g);
    set_in(pol, s, d, g);
    tick();
  endtask

  typedef struct {
    bit          pol;
    bit          s;
    logic [63:0] d;
    logic [3:0]  g;      // {gnt_fwd_even, gnt_fwd_odd, gnt_pe_even, gnt_pe_odd}
    bit          e_ri;
    logic [3:0]  e_req;  // {req_fwd_even, req_fwd_odd, req_pe_even, req_pe_odd}
    logic [3:0]  e_ce;
    logic [3:0]  e_co;
    int          dsel;   // 1: data_out_fwd_even, 2: data_out_pe_odd
    logic [63:0] e_dat;
  } vec_t;

  localparam logic [63:0] F0 = 64'hAB03_CDEF_0123_4567;
  localparam logic [63:0] F1 = 64'h5A00_1234_5678_9ABC;

  vec_t tbl[8];

  initial begin
    logic [63:0] f;
    logic [63:0] fnew;
    rst = 1'b1;
    polarity = 1'b0; si = 1'b0; di = 64'd0;
    {gnt_fwd_even, gnt_fwd_odd, gnt_pe_even, gnt_pe_odd} = 4'b0000;
    m_drop = 1'b0;

    tbl[0] = '{1'b0, 1'b1, F0,    4'b0000, 1'b1, 4'b0000, 4'd0, 4'd0, 0, 64'd0};
    tbl[1] = '{1'b1, 1'b0, 64'd0, 4'b0000, 1'b1, 4'b1000, 4'd1, 4'd0, 1, 64'hAB02_CDEF_0123_4567};
    tbl[2] = '{1'b1, 1'b0, 64'd0, 4'b1000, 1'b1, 4'b1000, 4'd1, 4'd0, 0, 64'd0};
    tbl[3] = '{1'b1, 1'b1, F1,    4'b0000, 1'b1, 4'b0000, 4'd0, 4'd0, 0, 64'd0};
    tbl[4] = '{1'b0, 1'b0, 64'd0, 4'b0000, 1'b1, 4'b0001, 4'd0, 4'd1, 2, F1};
    tbl[5] = '{1'b0, 1'b0, 64'd0, 4'b0101, 1'b1, 4'b0001, 4'd0, 4'd1, 0, 64'd0};
    tbl[6] = '{1'b0, 1'b0, 64'd0, 4'b0100, 1'b1, 4'b0000, 4'd0, 4'd0, 0, 64'd0};
    tbl[7] = '{1'b1, 1'b0, 64'd0, 4'b1111, 1'b1, 4'b0000, 4'd0, 4'd0, 0, 64'd0};

    // Reset held with polarity toggling
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_in(i[0], 1'b0, 64'd0, 4'b0000);
      chk("rst_ri", ri, 1'b1);
      chk("rst_req", {req_fwd_even, req_fwd_odd, req_pe_even, req_pe_odd}, 4'b0000);
      chk("rst_counts", {count_even, count_odd}, 8'h00);
      chk("rst_drop", drop_err, 1'b0);
      @(posedge clk); #1;
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) cyc(i[0], 1'b0, 64'd0, 4'b0000);

    // Directed vectors: forward path, PE path, grant filtering
    for (int i = 0; i < 8; i++) begin
      set_in(tbl[i].pol, tbl[i].s, tbl[i].d, tbl[i].g);
      chk($sformatf("vec%0d_ri", i), ri, tbl[i].e_ri);
      chk($sformatf("vec%0d_req", i), {req_fwd_even, req_fwd_odd, req_pe_even, req_pe_odd}, tbl[i].e_req);
      chk($sformatf("vec%0d_count_even", i), count_even, tbl[i].e_ce);
      chk($sformatf("vec%0d_count_odd", i), count_odd, tbl[i].e_co);
      if (tbl[i].dsel == 1) chk($sformatf("vec%0d_fwd_even_data", i), data_out_fwd_even, tbl[i].e_dat);
      if (tbl[i].dsel == 2) chk($sformatf("vec%0d_pe_odd_data", i), data_out_pe_odd, tbl[i].e_dat);
      tick();
    end

    // Fill even VC, overflow, pop once, push across the wrap, drain in order
    for (int i = 0; i < 8; i++) begin
      f = {8'hC0 + 8'(i), 8'(i), 16'hBEEF, 32'(i)};
      cyc(1'b0, 1'b1, f, 4'b0000);
    end
    set_in(1'b0, 1'b1, 64'hDEAD_DEAD_DEAD_DEAD, 4'b0000);
    chk("full_ri", ri, 1'b0);
    chk("full_count", count_even, 4'd8);
    tick();
    set_in(1'b0, 1'b0, 64'd0, 4'b0000);
    chk("drop_flag", drop_err, 1'b1);
    chk("drop_count", count_even, 4'd8);
    tick();
    cyc(1'b1, 1'b0, 64'd0, 4'b1010);
    cyc(1'b0, 1'b1, 64'hC8_05_F00D_0000_0008, 4'b0000);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 64'd0, 4'b1010);
    set_in(1'b1, 1'b0, 64'd0, 4'b0000);
    chk("drained_even", count_even, 4'd0);
    tick();

    // Asynchronous reset between edges with five odd flits buffered
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, {8'h70, 8'(i + 1), 48'(i)}, 4'b0000);
    set_in(1'b0, 1'b0, 64'd0, 4'b0000);
    chk("pre_rst_count_odd", count_odd, 4'd5);
    chk("pre_rst_req_odd", req_fwd_odd | req_pe_odd, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_count_odd", count_odd, 4'd0);
    chk("async_rst_req", {req_fwd_even, req_fwd_odd, req_pe_even, req_pe_odd}, 4'b0000);
    chk("async_rst_drop", drop_err, 1'b0);
    q_e.delete();
    q_o.delete();
    m_drop = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    fnew = 64'h3C05_AAAA_5555_1234;
    cyc(1'b1, 1'b1, fnew, 4'b0000);
    set_in(1'b0, 1'b0, 64'd0, 4'b0000);
    chk("post_rst_req_fwd_odd", req_fwd_odd, 1'b1);
    chk("post_rst_head", data_out_fwd_odd, 64'h3C04_AAAA_5555_1234);
    tick();
    cyc(1'b0, 1'b0, 64'd0, 4'b0100);
    set_in(1'b0, 1'b0, 64'd0, 4'b0000);
    chk("post_rst_popped", count_odd, 4'd0);
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      f = {$urandom, $urandom};
      if ($urandom_range(0, 2) == 0) f[55:48] = 8'd0;
      cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), f, 4'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/router_vc_input.md
Name: router_vc_input

Overview:
- Parametrised input port for the ring router, successor to the single-direction input buffer.
- Holds two virtual-channel FIFOs, even and odd, each DEPTH entries deep. The link polarity selects which VC is written and which is drained.
- Routes each head flit to the next-hop output or the local PE from its hop field, and decrements the hop field on the forward path.
- Exposes true full/empty and occupancy, and flags dropped writes.

Parameters:
- DATA_WIDTH, 64, flit width in bits.
- DEPTH, 8, entries per VC FIFO; must be a power of 2 and at least 2.
- PTR_W, 3, pointer width, equal to log2(DEPTH).
- HOP_MSB, 55, MSB of the hop-count field.
- HOP_LSB, 48, LSB of the hop-count field.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- polarity  in  1  link phase: 1 = odd write phase / even read phase; 0 = even write phase / odd read phase.
- si  in  1  upstream send strobe.
- ri  out  1  ready to upstream.
- di  in  DATA_WIDTH  upstream flit.
- req_fwd_even, req_fwd_odd  out  1 each  request to the next-hop output arbiter.
- req_pe_even, req_pe_odd  out  1 each  request to the PE output arbiter.
- gnt_fwd_even, gnt_fwd_odd, gnt_pe_even, gnt_pe_odd  in  1 each  single-cycle grant pulses.
- data_out_fwd_even, data_out_fwd_odd  out  DATA_WIDTH each  head flit with hop field decremented by 1.
- data_out_pe_even, data_out_pe_odd  out  DATA_WIDTH each  head flit, unmodified.
- count_even, count_odd  out  PTR_W+1 each  occupancy, range 0..DEPTH.
- drop_err  out  1  sticky: a write was attempted while not ready.

Behaviour:

Reset
- rst low clears, asynchronously: all pointers, counts and drop_err.
- Outputs while reset is held: ri=1, all req_*=0, count_*=0. data_out_* are don't-care. FIFO storage is not cleared.
- Reset asserted mid-transfer discards all buffered flits. The first write after release lands in entry 0.

Write side
- Write VC = odd when polarity=1, even when polarity=0.
- ri is combinational: ri = !full of the current write VC. A FIFO is full when count == DEPTH, so all DEPTH entries are usable.
- Push occurs when si & ri. di is written at the tail, tail increments modulo DEPTH, count increments.
- si & !ri: flit is dropped, no state change except drop_err <= 1. drop_err clears only on reset.

Read side
- Read VC = the VC not being written: even when polarity=1, odd when polarity=0.
- A VC requests only when it is the read VC and count != 0.
- Routing field hop = head[HOP_MSB:HOP_LSB]:
  - hop == 0 -> assert req_pe_<vc>.
  - otherwise assert req_fwd_<vc>.
  - req_fwd and req_pe for one VC are never both high.
- data_out_* are combinational from the head entry (first-word fall-through), valid whenever the matching req is high:
  - fwd outputs carry hop-1 in the hop field; all other bits pass unchanged.
  - pe outputs carry the head entry unmodified.
- Pop occurs when a grant arrives while its matching req is high: head increments modulo DEPTH, count decrements. The next head appears on the following cycle; at most one pop per VC per cycle.
- A grant with no matching req is ignored. If fwd and pe grants for the same VC coincide, only the one matching the asserted req pops.

Concurrency
- Push and pop on the same VC in one cycle cannot occur by construction (polarity separation).
- Push on one VC and pop on the other in the same cycle are independent and both take effect.

Arithmetic
- Pointers wrap from DEPTH-1 to 0.
- count is PTR_W+1 bits wide and saturates logically at DEPTH (full) and 0 (empty) via ri and req gating; it never wraps.

Latency
- A flit pushed on cycle N is requestable on the first cycle at or after N+1 in which its VC is the read VC.

Test Plan:
1. Reset and idle: hold rst low, then release with polarity toggling every cycle and si=0 -> ri=1, all req=0, count_even=count_odd=0, drop_err=0.
2. Forward path: polarity=0, si=1, di hop=8'h03 -> count_even=1. Next cycle polarity=1 -> req_fwd_even=1 and data_out_fwd_even hop field = 8'h02. Pulse gnt_fwd_even -> count_even=0 and req drops next cycle.
3. PE path: push an odd flit with hop=8'h00 at polarity=1. Next cycle polarity=0 -> req_pe_odd=1, req_fwd_odd=0, and data_out_pe_odd equals the pushed flit exactly.
4. Full and drop: 8 even pushes with no grants -> count_even=8 and ri=0 at polarity=0. 9th si -> drop_err=1, count_even stays 8. Pop once, then push -> wrap to entry 0 and FIFO order preserved for all 8 flits.
5. Mixed order: interleave even and odd pushes of 4 flits each with alternating hop values, grant randomly -> each VC drains in FIFO order, no duplicates, and each flit's req type matches its hop.
6. Mid-operation reset: assert rst low asynchronously between clock edges with count_odd=5 -> counts 0 and req_*=0 immediately. After release, a new flit is popped first.
